// File: rtl/elastic_credit_sender_dataless_if.sv
// Handshake and credit bundle between a token producer and the credit sender.
// The master modport is the sender's view. The slave modport is the upstream/link environment's view.
interface elastic_credit_sender_dataless_if #(
  parameter int unsigned NUM_CREDITS = 4
);
  localparam int unsigned CW = $clog2(NUM_CREDITS + 1);

  logic          ins_valid;
  logic          ins_ready;
  logic          outs_valid;
  logic          outs_ready;
  logic          credit_return;
  logic [CW-1:0] credit_count;
  logic          credit_overflow;

  modport master (
    input  ins_valid,
    output ins_ready,
    output outs_valid,
    input  outs_ready,
    input  credit_return,
    output credit_count,
    output credit_overflow
  );

  modport slave (
    output ins_valid,
    input  ins_ready,
    input  outs_valid,
    output outs_ready,
    output credit_return,
    input  credit_count,
    input  credit_overflow
  );
endinterface

// File: rtl/elastic_credit_sender_dataless.sv
// Credit-based dataless token sender with a one-slot output register.
// Optional macro ELASTIC_CREDIT_BYPASS_EN lets a returned credit enable an accept in the same cycle.
module elastic_credit_sender_dataless #(
  parameter int unsigned NUM_CREDITS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  elastic_credit_sender_dataless_if.master      bus
);
  localparam int unsigned   CW      = $clog2(NUM_CREDITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_CREDITS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          out_valid_r;
  logic          out_valid_nxt_s;
  logic          overflow_r;
  logic          overflow_nxt_s;
  logic          credit_ok_s;
  logic          ins_ready_s;
  logic          accept_s;
  logic          send_s;

  // Handshake qualifiers; the bypass build adds the credit_return -> ins_ready path
  always_comb begin
    credit_ok_s = 1'b0;
`ifdef ELASTIC_CREDIT_BYPASS_EN
    credit_ok_s = (cnt_r != ZERO_CNT) | bus.credit_return;
`else
    credit_ok_s = (cnt_r != ZERO_CNT);
`endif
    ins_ready_s = credit_ok_s & (~out_valid_r | bus.outs_ready);
    accept_s    = bus.ins_valid & ins_ready_s;
    send_s      = out_valid_r & bus.outs_ready;
  end

  // Output register next state: a fresh accept wins over a send in the same cycle
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    if (accept_s) begin
      out_valid_nxt_s = 1'b1;
    end else if (send_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Credit counter next state: a credit is consumed at accept, not at send
  always_comb begin
    cnt_nxt_s      = cnt_r;
    overflow_nxt_s = overflow_r;
    case ({accept_s, bus.credit_return})
      2'b10: cnt_nxt_s = cnt_r - ONE_CNT;
      2'b01: begin
        if (cnt_r < MAX_CNT) begin
          cnt_nxt_s = cnt_r + ONE_CNT;
        end else begin
          cnt_nxt_s      = cnt_r;
          overflow_nxt_s = 1'b1;
        end
      end
      2'b11:   cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // State registers; a reset drops any held token and restores the full credit pool
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= MAX_CNT;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      overflow_r  <= overflow_nxt_s;
    end
  end

  assign bus.ins_ready       = ins_ready_s;
  assign bus.outs_valid      = out_valid_r;
  assign bus.credit_count    = cnt_r;
  assign bus.credit_overflow = overflow_r;
endmodule

// File: tb/tb_elastic_credit_sender_dataless.sv
// Directed bench for elastic_credit_sender_dataless with NUM_CREDITS=4.
// Handles both the default build and the ELASTIC_CREDIT_BYPASS_EN build.
module tb_elastic_credit_sender_dataless;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  elastic_credit_sender_dataless_if #(.NUM_CREDITS(4)) bus ();

  elastic_credit_sender_dataless #(.NUM_CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    rst               = 1'b0;
    bus.ins_valid     = 1'b0;
    bus.outs_ready    = 1'b0;
    bus.credit_return = 1'b0;

    // Reset state
    #12;
    chk("rst_outs_valid", 32'(bus.outs_valid), 32'd0);
    chk("rst_count", 32'(bus.credit_count), 32'd4);
    chk("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
    chk("rst_overflow", 32'(bus.credit_overflow), 32'd0);
    rst = 1'b1;

    // Test 1: streaming until credits run out
    bus.ins_valid  = 1'b1;
    bus.outs_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_ins_ready", 32'(bus.ins_ready), 32'd1);
      chk("t1_count", 32'(bus.credit_count), 32'(4 - i));
      chk("t1_outs_valid", 32'(bus.outs_valid), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    chk("t1_c4_ins_ready", 32'(bus.ins_ready), 32'd0);
    chk("t1_c4_count", 32'(bus.credit_count), 32'd0);
    chk("t1_c4_outs_valid", 32'(bus.outs_valid), 32'd1);
    tick();
    chk("t1_c5_ins_ready", 32'(bus.ins_ready), 32'd0);
    chk("t1_c5_outs_valid", 32'(bus.outs_valid), 32'd0);
    chk("t1_c5_count", 32'(bus.credit_count), 32'd0);

    // Test 2: single credit return at cnt=0
    bus.credit_return = 1'b1;
    #1;
`ifdef ELASTIC_CREDIT_BYPASS_EN
    chk("t2_pulse_ins_ready", 32'(bus.ins_ready), 32'd1);
    tick();
    bus.credit_return = 1'b0;
    #1;
    chk("t2_count_after", 32'(bus.credit_count), 32'd0);
    chk("t2_outs_valid", 32'(bus.outs_valid), 32'd1);
    chk("t2_ins_ready_after", 32'(bus.ins_ready), 32'd0);
`else
    chk("t2_pulse_ins_ready", 32'(bus.ins_ready), 32'd0);
    tick();
    bus.credit_return = 1'b0;
    #1;
    chk("t2_count_after", 32'(bus.credit_count), 32'd1);
    chk("t2_ins_ready_after", 32'(bus.ins_ready), 32'd1);
    tick();
    chk("t2_count_used", 32'(bus.credit_count), 32'd0);
    chk("t2_outs_valid", 32'(bus.outs_valid), 32'd1);
`endif
    bus.ins_valid     = 1'b0;
    bus.credit_return = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.credit_return = 1'b0;
    #1;
    chk("t2_refill_count", 32'(bus.credit_count), 32'd4);
    chk("t2_refill_overflow", 32'(bus.credit_overflow), 32'd0);
    chk("t2_refill_outs_valid", 32'(bus.outs_valid), 32'd0);

    // Test 3: backpressure on the link
    bus.outs_ready = 1'b0;
    bus.ins_valid  = 1'b1;
    #1;
    chk("t3_first_ready", 32'(bus.ins_ready), 32'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_outs_valid", 32'(bus.outs_valid), 32'd1);
      chk("t3_hold_ins_ready", 32'(bus.ins_ready), 32'd0);
      chk("t3_hold_count", 32'(bus.credit_count), 32'd3);
      tick();
    end
    bus.outs_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(bus.ins_ready), 32'd1);
    tick();
    chk("t3_count", 32'(bus.credit_count), 32'd2);
    chk("t3_outs_valid", 32'(bus.outs_valid), 32'd1);

    // Test 4: accept and credit return in the same cycle
    bus.credit_return = 1'b1;
    #1;
    chk("t4_ins_ready", 32'(bus.ins_ready), 32'd1);
    tick();
    chk("t4_count", 32'(bus.credit_count), 32'd2);
    chk("t4_overflow", 32'(bus.credit_overflow), 32'd0);
    bus.ins_valid     = 1'b0;
    bus.credit_return = 1'b0;
    tick();
    chk("t4_drain_outs_valid", 32'(bus.outs_valid), 32'd0);
    chk("t4_drain_count", 32'(bus.credit_count), 32'd2);
    bus.credit_return = 1'b1;
    tick();
    tick();
    bus.credit_return = 1'b0;
    #1;
    chk("t4_refill_count", 32'(bus.credit_count), 32'd4);

    // Test 5: credit return while already full
    bus.credit_return = 1'b1;
    tick();
    bus.credit_return = 1'b0;
    #1;
    chk("t5_overflow", 32'(bus.credit_overflow), 32'd1);
    chk("t5_count", 32'(bus.credit_count), 32'd4);
    tick();
    tick();
    chk("t5_overflow_sticky", 32'(bus.credit_overflow), 32'd1);
    chk("t5_count_hold", 32'(bus.credit_count), 32'd4);

    // Test 6: asynchronous reset mid-stream
    bus.ins_valid  = 1'b1;
    bus.outs_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.ins_valid  = 1'b0;
    bus.outs_ready = 1'b0;
    #1;
    chk("t6_pre_count", 32'(bus.credit_count), 32'd1);
    chk("t6_pre_outs_valid", 32'(bus.outs_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_outs_valid", 32'(bus.outs_valid), 32'd0);
    chk("t6_rst_count", 32'(bus.credit_count), 32'd4);
    chk("t6_rst_overflow", 32'(bus.credit_overflow), 32'd0);
    chk("t6_rst_ins_ready", 32'(bus.ins_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_post_count", 32'(bus.credit_count), 32'd4);
    chk("t6_post_outs_valid", 32'(bus.outs_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
